// File: rtl/instruction_cache.sv
// Direct-mapped read-only I-cache; zero-latency hits, block refill on miss.
// Ports: CLK/RESET, CPU side (ADDRESS, READ, INSTRUCTION, BUSYWAIT),
//        memory side (MEM_READ, MEM_ADDRESS, MEM_READDATA, MEM_BUSYWAIT).
module instruction_cache #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 25
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  ADDRESS,
  input  logic         READ,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam int SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MEMRD  = 2'd1,
    S_UPDATE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [SETS-1:0] valid_q, valid_d;
  logic [27:0] mem_address_q, mem_address_d;
  logic issued_q, issued_d;

  logic [TAG_BITS-1:0] tag_q [SETS];
  logic [127:0] data_q [SETS];

  logic [TAG_BITS-1:0] addr_tag;
  logic [INDEX_BITS-1:0] addr_idx;
  logic [1:0] offset;
  logic hit;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic unused_addr;

  assign addr_tag = ADDRESS[31:4+INDEX_BITS];
  assign addr_idx = ADDRESS[3+INDEX_BITS:4];
  assign offset = ADDRESS[3:2];
  assign unused_addr = ^ADDRESS[1:0];

  // Install location always comes from the latched request, so the CPU
  // may move ADDRESS while the fill is in flight.
  assign fill_idx = mem_address_q[INDEX_BITS-1:0];
  assign fill_tag = mem_address_q[27:INDEX_BITS];

  assign hit = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      mem_address_q <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      mem_address_q <= mem_address_d;
      issued_q <= issued_d;
    end
  end

  // Arrays are not reset; valid_q alone decides whether a line counts.
  always_ff @(posedge CLK) begin
    if (state_q == S_UPDATE) begin
      tag_q[fill_idx] <= fill_tag;
      data_q[fill_idx] <= MEM_READDATA;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    mem_address_d = mem_address_q;
    issued_d = issued_q;
    unique case (state_q)
      S_IDLE: begin
        if (READ && !hit) begin
          state_d = S_MEMRD;
          mem_address_d = {addr_tag, addr_idx};
          issued_d = 1'b0;
        end
      end
      // The first edge only marks the request as seen; a low
      // MEM_BUSYWAIT then may still be left over from the last fill.
      S_MEMRD: begin
        issued_d = 1'b1;
        if (issued_q && !MEM_BUSYWAIT) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        valid_d[fill_idx] = 1'b1;
        issued_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MEM_READ = (state_q == S_MEMRD);
    MEM_ADDRESS = mem_address_q;
    BUSYWAIT = (READ && !hit) || (state_q != S_IDLE);
    INSTRUCTION = data_q[addr_idx][{offset, 5'b0} +: 32];
  end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
Direct-mapped, read-only instruction cache between the IF stage and the block-based instruction memory. It serves 32-bit instructions to the CPU with zero-latency hits. On a miss it acts as the initiator of the READ/BUSYWAIT block protocol and fetches a 16-byte block addressed by a 28-bit block address. The CPU side stalls on BUSYWAIT until the instruction is valid.

Parameters:
INDEX_BITS, 3, number of set-index bits; number of sets = 2**INDEX_BITS (default 8 sets of 16 bytes).
TAG_BITS, 25, tag width; must equal 28 - INDEX_BITS.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RESET  input  1  asynchronous, active-high reset.
ADDRESS  input  32  byte address of the instruction (PC); bits [1:0] ignored.
READ  input  1  CPU instruction-fetch request.
INSTRUCTION  output  32  fetched instruction word.
BUSYWAIT  output  1  CPU stall; 1 while the request cannot be served this cycle.
MEM_READ  output  1  block read request to instruction memory.
MEM_ADDRESS  output  28  block address sent to memory: {tag, index}.
MEM_READDATA  input  128  block from memory; byte 0 is at [7:0].
MEM_BUSYWAIT  input  1  memory busy; 0 means MEM_READDATA is valid.

Behaviour:
- Address split: offset = ADDRESS[3:2] (word select); index = ADDRESS[3+INDEX_BITS:4]; tag = ADDRESS[31:4+INDEX_BITS].
- Storage per set: valid bit, TAG_BITS tag, 128-bit block.
- Hit (combinational): valid[index] && tag_array[index] == tag.
- INSTRUCTION (combinational): word offset of data_array[index].
  - Offset 0 selects [31:0], offset 1 selects [63:32], offset 2 selects [95:64], offset 3 selects [127:96].
  - Value is don't-care while BUSYWAIT=1.
- BUSYWAIT = (READ && !hit) || state != IDLE. It is 0 when READ=0 and state is IDLE.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE: on a rising edge with READ=1 and !hit, latch {tag, index} into MEM_ADDRESS and go to MEM_READ. A hit stays in IDLE (0 extra cycles).
  - MEM_READ:
    - MEM_READ=1; MEM_ADDRESS held stable.
    - Internal flag `issued` is set on the first edge in this state.
    - Go to UPDATE on a rising edge where issued=1 and MEM_BUSYWAIT=0. This guards against a stale 0 from the previous transaction.
  - UPDATE:
    - MEM_READ=0.
    - On the edge: write MEM_READDATA into data_array[index], set tag_array[index] and valid[index]=1.
    - Go to IDLE.
    - The next IDLE cycle is a hit if READ and ADDRESS are unchanged.
- Miss penalty: request cycle + memory latency + 1 UPDATE cycle. With default memory, the CPU sees BUSYWAIT for ≥3 cycles.
- READ deasserted or ADDRESS changed mid-fill:
  - The fill completes using the latched MEM_ADDRESS, because memory cannot abort.
  - The block is installed at the latched index.
  - The new request is evaluated in IDLE afterwards.
- Refill replaces the valid block at that index unconditionally. The cache is read-only, so there is no writeback.
- Reset (async, any state, including mid-fill):
  - State goes to IDLE; all valid bits are cleared; MEM_READ=0; MEM_ADDRESS=0; issued=0.
  - BUSYWAIT = READ (every access misses).
  - Tag and data arrays need not be cleared.
  - After release, a fresh fill restarts from IDLE.

Test Plan:
- Cold miss: RESET pulse, then READ=1, ADDRESS=0x0000_0004 -> MEM_READ=1 with MEM_ADDRESS=0x0000000. BUSYWAIT holds 1 until UPDATE, then falls; INSTRUCTION = bytes 4..7 of block 0.
- Hit after fill: ADDRESS 0x0, 0x8, 0xC in consecutive cycles -> BUSYWAIT=0 every cycle, MEM_READ stays 0, INSTRUCTION = words 0, 2, 3 of block 0.
- Conflict miss: fill 0x0000_0000, then read 0x0000_0080 (same index 0, tag 1) -> MEM_ADDRESS=0x0000008 refill. Re-reading 0x0 then misses again with MEM_ADDRESS=0x0000000.
- Index coverage: read 0x00, 0x10, …, 0x70 -> 8 fills with MEM_ADDRESS 0x0–0x7. A second pass over all 8 addresses is all hits.
- Stale-busywait guard: model memory that keeps MEM_BUSYWAIT=0 for one cycle after MEM_READ rises -> FSM must not leave MEM_READ until a later edge with MEM_BUSYWAIT=0.
- Reset mid-fill: assert RESET while in MEM_READ -> MEM_READ=0 immediately (async). After release, a previously filled address misses again and re-fetches correctly.
